// File: rtl/reg_file.sv
// rtl/reg_file.sv - byte-maskable register file, one write port, two combinational read ports
//
// Purpose
//    DEPTH x WIDTH register file with a single byte-masked write port, two
//    independent combinational read ports, optional hard-wired zero register,
//    optional read-during-write bypass and an 8-bit committed-write counter.
//
// Parameters
//    WIDTH    data bits per register (multiple of 8, >= 8)
//    DEPTH    number of registers (power of two, >= 2)
//    AW       address width, derived from DEPTH
//    ZERO_R0  1: register 0 reads as zero and never takes a write
//    BYPASS   1: a read of the address being written shows the merged write value
//
// Ports
//    clk      rising-edge clock
//    clrn     asynchronous active-low clear of all storage and wcount
//    wen      active-low write enable
//    waddr    write address
//    wdata    write data
//    wbe      active-high byte write mask, bit i covers wdata[8i+7:8i]
//    raddr1   read port 1 address
//    raddr2   read port 2 address
//    rdata1   read port 1 data
//    rdata2   read port 2 data
//    wcount   number of committed writes, wraps 255 -> 0

`timescale 1ns/1ps

module reg_file #(
   parameter  int WIDTH   = 32,
   parameter  int DEPTH   = 32,
   localparam int AW      = $clog2(DEPTH),
   parameter  int ZERO_R0 = 1,
   parameter  int BYPASS  = 1
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               wen,
   input  logic [AW-1:0]      waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] wbe,
   input  logic [AW-1:0]      raddr1,
   input  logic [AW-1:0]      raddr2,
   output logic [WIDTH-1:0]   rdata1,
   output logic [WIDTH-1:0]   rdata2,
   output logic [7:0]         wcount
);

   localparam int BYTES = WIDTH / 8;
   localparam bit ZR0   = (ZERO_R0 != 0);
   localparam bit BYP   = (BYPASS != 0);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [7:0]       wcount_q;
   logic [7:0]       wcount_d;
   logic             arm_q;

   logic [WIDTH-1:0] merged_d;
   logic             wr_zero;
   logic             commit;
   logic             bypass_en;

   // arm_q is cleared with the storage and only sets on the falling clk edge
   // after clrn has gone high. A rising edge that coincides with (or closely
   // follows) clrn deassertion therefore never commits a write, while a clrn
   // release in the first half of a cycle still lets the next rising edge commit.
   always_ff @(negedge clk or negedge clrn) begin
      if (!clrn) begin
         arm_q <= 1'b0;
      end else begin
         arm_q <= 1'b1;
      end
   end

   // Post-write value of the addressed register: new bytes where wbe is set,
   // stored bytes elsewhere. Shared by the storage update and the bypass path.
   always_comb begin
      merged_d = mem_q[waddr];
      for (int b = 0; b < BYTES; b++) begin
         if (wbe[b]) begin
            merged_d[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      wr_zero   = ZR0 && (waddr == '0);
      commit    = clrn && arm_q && !wen && (wbe != '0) && !wr_zero;
      // Bypass follows the same gating as a write that could take effect, so
      // the forwarded value always matches what the edge will store.
      bypass_en = BYP && clrn && arm_q && !wen;
      wcount_d  = commit ? (wcount_q + 8'd1) : wcount_q;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wcount_q <= '0;
      end else begin
         if (commit) begin
            mem_q[waddr] <= merged_d;
         end
         wcount_q <= wcount_d;
      end
   end

   // Read ports: clear forces zero immediately (covers the bypass path too),
   // then the zero register, then bypass, then storage.
   always_comb begin
      if (!clrn) begin
         rdata1 = '0;
      end else if (ZR0 && (raddr1 == '0)) begin
         rdata1 = '0;
      end else if (bypass_en && (raddr1 == waddr)) begin
         rdata1 = merged_d;
      end else begin
         rdata1 = mem_q[raddr1];
      end
   end

   always_comb begin
      if (!clrn) begin
         rdata2 = '0;
      end else if (ZR0 && (raddr2 == '0)) begin
         rdata2 = '0;
      end else if (bypass_en && (raddr2 == waddr)) begin
         rdata2 = merged_d;
      end else begin
         rdata2 = mem_q[raddr2];
      end
   end

   assign wcount = wcount_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file

`timescale 1ns/1ps

module tb_reg_file;

   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic        wen = 1'b1;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wbe = '0;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;

   logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
   logic [7:0]  a_wcount, b_wcount;

   logic        c_wen = 1'b1;
   logic [2:0]  c_waddr = '0;
   logic [15:0] c_wdata = '0;
   logic [1:0]  c_wbe = '0;
   logic [2:0]  c_raddr1 = '0;
   logic [2:0]  c_raddr2 = '0;
   logic [15:0] c_rdata1, c_rdata2;
   logic [7:0]  c_wcount;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   reg_file u_a (
      .clk(clk), .clrn(clrn), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rdata1), .rdata2(a_rdata2), .wcount(a_wcount)
   );

   reg_file #(.BYPASS(0)) u_b (
      .clk(clk), .clrn(clrn), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2), .wcount(b_wcount)
   );

   reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0)) u_c (
      .clk(clk), .clrn(clrn), .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata), .wbe(c_wbe),
      .raddr1(c_raddr1), .raddr2(c_raddr2), .rdata1(c_rdata1), .rdata2(c_rdata2), .wcount(c_wcount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset and writes ignored during clear
      #1 clrn = 1'b0;
      #1;
      chk("rst_rdata1", a_rdata1, 32'h0);
      chk("rst_rdata2", a_rdata2, 32'h0);
      chk("rst_wcount", a_wcount, 8'd0);
      wen = 1'b0; waddr = 5'd5; wdata = 32'h12345678; wbe = 4'hF; raddr1 = 5'd5;
      #1;
      chk("rst_bypass_zero", a_rdata1, 32'h0);
      step();
      chk("rst_write_ignored", a_rdata1, 32'h0);
      chk("rst_wcount_held", a_wcount, 8'd0);

      // ---- clear released on a rising edge with a write pending: no commit
      @(posedge clk);
      clrn = 1'b1;
      #1;
      chk("release_edge_wcount", a_wcount, 8'd0);
      chk("release_edge_data", a_rdata1, 32'h0);
      wen = 1'b1;
      step();
      chk("release_no_commit", a_rdata1, 32'h0);

      // ---- full write to addr 5, bypass visible before the edge on u_a only
      wen = 1'b0; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF; raddr1 = 5'd5;
      #1;
      chk("wr5_bypass_a", a_rdata1, 32'hDEADBEEF);
      chk("wr5_nobypass_b", b_rdata1, 32'h0);
      step();
      wen = 1'b1;
      #1;
      chk("wr5_read_a", a_rdata1, 32'hDEADBEEF);
      chk("wr5_read_b", b_rdata1, 32'hDEADBEEF);
      chk("wr5_wcount", a_wcount, 8'd1);

      // ---- byte mask 0101 on addr 5, both ports reading the same address
      wen = 1'b0; wdata = 32'h11223344; wbe = 4'b0101; raddr2 = 5'd5;
      step();
      wen = 1'b1;
      #1;
      chk("mask_port1", a_rdata1, 32'hDE22BE44);
      chk("mask_port2", a_rdata2, 32'hDE22BE44);
      chk("mask_wcount", a_wcount, 8'd2);

      // ---- wen=1 leaves addr 7 untouched
      waddr = 5'd7; wdata = 32'hFFFFFFFF; wbe = 4'hF; raddr1 = 5'd7;
      step();
      chk("wen_hi_data", a_rdata1, 32'h0);
      chk("wen_hi_wcount", a_wcount, 8'd2);

      // ---- writes to register 0 never commit and never bypass
      wen = 1'b0; waddr = 5'd0; raddr1 = 5'd0;
      #1;
      chk("r0_bypass", a_rdata1, 32'h0);
      step();
      wen = 1'b1;
      #1;
      chk("r0_read", a_rdata1, 32'h0);
      chk("r0_wcount", a_wcount, 8'd2);

      // ---- all-zero byte mask does not commit
      wen = 1'b0; waddr = 5'd6; wbe = 4'h0; raddr1 = 5'd6;
      step();
      wen = 1'b1;
      #1;
      chk("wbe0_wcount", a_wcount, 8'd2);
      chk("wbe0_data", a_rdata1, 32'h0);

      // ---- bypass of a fresh write to addr 3, port 2 on another address
      wen = 1'b0; waddr = 5'd3; wdata = 32'h0000ABCD; wbe = 4'hF; raddr1 = 5'd3; raddr2 = 5'd5;
      #1;
      chk("byp3_a", a_rdata1, 32'h0000ABCD);
      chk("byp3_b_old", b_rdata1, 32'h0);
      chk("byp3_port2", a_rdata2, 32'hDE22BE44);
      step();
      wen = 1'b1;
      #1;
      chk("byp3_b_after", b_rdata1, 32'h0000ABCD);
      chk("byp3_wcount", a_wcount, 8'd3);

      // ---- bypass of a partial write shows merged bytes
      wen = 1'b0; waddr = 5'd5; wdata = 32'hAA000000; wbe = 4'b1000; raddr1 = 5'd5;
      #1;
      chk("bypmerge_a", a_rdata1, 32'hAA22BE44);
      chk("bypmerge_b", b_rdata1, 32'hDE22BE44);
      step();
      wen = 1'b1;
      #1;
      chk("bypmerge_after", b_rdata1, 32'hAA22BE44);
      chk("bypmerge_wcount", b_wcount, 8'd4);

      // ---- second config: 16-bit, 8 deep, register 0 writable
      c_wen = 1'b0; c_waddr = 3'd0; c_wdata = 16'hBEEF; c_wbe = 2'b11; c_raddr1 = 3'd0;
      step();
      c_wen = 1'b0; c_waddr = 3'd7; c_wdata = 16'h1234; c_wbe = 2'b01;
      step();
      c_wen = 1'b1; c_raddr2 = 3'd7;
      #1;
      chk("c_r0_read", {16'h0, c_rdata1}, 32'h0000BEEF);
      chk("c_mask_read", {16'h0, c_rdata2}, 32'h00000034);
      chk("c_wcount", c_wcount, 8'd2);

      // ---- asynchronous clear between edges
      raddr1 = 5'd3; raddr2 = 5'd5;
      #2 clrn = 1'b0;
      #1;
      chk("clr_rdata1", a_rdata1, 32'h0);
      chk("clr_rdata2", a_rdata2, 32'h0);
      chk("clr_wcount", a_wcount, 8'd0);
      chk("clr_c_r0", {16'h0, c_rdata1}, 32'h0);
      step();
      clrn = 1'b1;
      step();
      chk("clr_no_retain", a_rdata1, 32'h0);
      chk("clr_no_retain2", b_rdata2, 32'h0);

      // ---- counter wrap: 255 commits, then one more
      wen = 1'b0; waddr = 5'd9; wbe = 4'hF; raddr1 = 5'd9;
      for (int i = 0; i < 255; i++) begin
         wdata = i;
         step();
      end
      wen = 1'b1;
      #1;
      chk("wrap_255", a_wcount, 8'd255);
      chk("wrap_data", a_rdata1, 32'd254);
      wen = 1'b0; wdata = 32'h0000_00FF;
      step();
      wen = 1'b1;
      #1;
      chk("wrap_0", a_wcount, 8'd0);
      chk("wrap_last", a_rdata1, 32'h0000_00FF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
